// File: rtl/io_uart_tx_pkg.sv
// io_uart_tx_pkg -- shared definitions for the memory-mapped UART transmitter.
// Contents: register offsets (decoded from addr[3:2]), STATUS and CTRL bit
// positions, the transmit FSM state encoding, the FIFO count width, and a
// helper that maps a programmed divisor onto the bit period actually used.
package io_uart_tx_pkg;

  // Register offsets as seen on addr[3:2]; addr[1:0] never take part in decode.
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  // STATUS bit positions.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 8;

  // CTRL bit positions.
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // FIFO occupancy width: holds 0..16 entries.
  localparam int CNT_W = 5;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // A programmed divisor of zero still has to produce a one-clock bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/sync_fifo_8b.sv
// sync_fifo_8b -- byte-wide synchronous FIFO used as the UART transmit queue.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   push, wdata     enqueue wdata; ignored when full unless a pop happens in
//                   the same clock, in which case the freed slot is reused
//   pop, rdata      rdata shows the head entry; pop removes it (ignored if empty)
//   full, empty     occupancy flags
//   count           number of stored entries, 0..DEPTH
module sync_fifo_8b
  import io_uart_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       wdata,
  input  logic             pop,
  output logic [7:0]       rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == {CNT_W{1'b0}});
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  // A pop in the same clock frees the slot the push lands in.
  assign push_ok = push & (~full | pop_ok);

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx -- memory-mapped 8N1 UART transmitter with a transmit FIFO.
// Registers (addr[3:2]): TXDATA (W), STATUS (R/W1C overflow), CTRL (R/W),
// DIVISOR (R/W, bit period in clocks, 0 treated as 1).
// Ports:
//   clk, rst        CPU clock, asynchronous active-high reset
//   nce             active-low chip enable qualifying we/re
//   we, re          register write / read strobes
//   addr            byte address, bits [3:2] select the register
//   wdata, rdata    store data in, combinational read data out
//   txd             serial line, idle high
//   irq             level interrupt: irq_en & FIFO empty & not busy
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nce,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam logic [15:0] DIV_RST = 16'(CLK_DIV);

  tx_state_e   state_q, state_d;
  logic [15:0] div_q, div_d;           // DIVISOR register as programmed
  logic [15:0] bit_div_q, bit_div_d;   // bit period frozen for the current frame
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  data_q, data_d;
  logic        txd_q, txd_d;
  logic        ovf_q, ovf_d;
  logic        tx_en_q, tx_en_d;
  logic        irq_en_q, irq_en_d;

  logic             wr_en;
  logic             rd_en;
  logic             txdata_wr;
  logic             busy;
  logic             bit_end;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_bits;

  assign wr_en       = ~nce & we;
  assign rd_en       = ~nce & re;
  assign txdata_wr   = wr_en & (addr[3:2] == REG_TXDATA);
  assign busy        = (state_q != ST_IDLE);
  assign bit_end     = (baud_cnt_q == (bit_div_q - 16'd1));
  // A byte leaves the FIFO when a frame may begin: from IDLE, or straight
  // out of the last STOP clock so consecutive frames have no idle gap.
  assign pop         = tx_en_q & ~fifo_empty &
                       ((state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_end));
  assign txd         = txd_q;
  assign irq         = irq_en_q & fifo_empty & ~busy;
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  sync_fifo_8b #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (txdata_wr),
    .wdata (wdata[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register-file writes; a TXDATA write into a full FIFO is only lost when
  // no pop frees a slot in the same clock.
  always_comb begin
    div_d    = div_q;
    ovf_d    = ovf_q;
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    if (wr_en) begin
      case (addr[3:2])
        REG_TXDATA: begin
          if (fifo_full & ~pop) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end
        REG_STATUS: begin
          if (wdata[STAT_OVF]) begin
            ovf_d = 1'b0;
          end else begin
            ovf_d = ovf_q;
          end
        end
        REG_CTRL: begin
          tx_en_d  = wdata[CTRL_TX_EN];
          irq_en_d = wdata[CTRL_IRQ_EN];
        end
        REG_DIVISOR: div_d = wdata[15:0];
        default:     div_d = div_q;
      endcase
    end else begin
      div_d = div_q;
    end
  end

  // Transmit FSM: each of START, 8 DATA bits and STOP lasts bit_div_q clocks.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    bit_div_d  = bit_div_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d    = ST_START;
          baud_cnt_d = 16'd0;
          data_d     = fifo_rdata;
          bit_div_d  = eff_div(div_q);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d    = ST_DATA;
          baud_cnt_d = 16'd0;
          bit_idx_d  = 3'd0;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_cnt_d = 16'd0;
          if (pop) begin
            state_d   = ST_START;
            data_d    = fifo_rdata;
            bit_div_d = eff_div(div_q);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the next state so txd changes on the same edge as the FSM.
  always_comb begin
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = data_d[bit_idx_d];
      default:  txd_d = 1'b1;
    endcase
  end

  // Combinational read mux; unselected or unqualified reads return zero.
  always_comb begin
    rdata = 32'h0000_0000;
    if (rd_en) begin
      case (addr[3:2])
        REG_STATUS: begin
          rdata[STAT_BUSY]                  = busy;
          rdata[STAT_FULL]                  = fifo_full;
          rdata[STAT_EMPTY]                 = fifo_empty;
          rdata[STAT_OVF]                   = ovf_q;
          rdata[STAT_CNT_MSB:STAT_CNT_LSB]  = fifo_count;
        end
        REG_CTRL: begin
          rdata[CTRL_TX_EN]  = tx_en_q;
          rdata[CTRL_IRQ_EN] = irq_en_q;
        end
        REG_DIVISOR: rdata[15:0] = div_q;
        default:     rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // State and register flops; reset forces the line idle and drops any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= DIV_RST;
      bit_div_q  <= eff_div(DIV_RST);
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      data_q     <= 8'd0;
      txd_q      <= 1'b1;
      ovf_q      <= 1'b0;
      tx_en_q    <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_div_q  <= bit_div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      txd_q      <= txd_d;
      ovf_q      <= ovf_d;
      tx_en_q    <= tx_en_d;
      irq_en_q   <= irq_en_d;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx -- self-checking bench for io_uart_tx.
// A behavioural model keeps the FIFO as a byte queue and the serial line as a
// queue of per-clock expected txd levels (one whole frame appended per pop).
// txd, irq and rdata are compared on every falling edge; directed scenarios
// add constant-valued checks on frame shape, overflow, divisor and reset.
module tb_io_uart_tx;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 8;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        nce   = 1'b1;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic [3:0]  addr  = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        txd;
  logic        irq;

  io_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .nce   (nce),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .txd   (txd),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0]  m_fifo[$];
  bit          m_line[$];
  logic [15:0] m_div    = 16'(CLK_DIV);
  bit          m_tx_en  = 1'b0;
  bit          m_irq_en = 1'b0;
  bit          m_ovf    = 1'b0;
  logic [7:0]  m_b;
  int          m_d;
  bit          m_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      m_line.delete();
      m_div    = 16'(CLK_DIV);
      m_tx_en  = 1'b0;
      m_irq_en = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      if (m_line.size() != 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && m_tx_en && m_fifo.size() != 0) begin
        m_b = m_fifo.pop_front();
        m_d = (m_div == 16'd0) ? 1 : int'(m_div);
        for (int k = 0; k < 10; k++) begin
          m_v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m_b[k-1];
          repeat (m_d) m_line.push_back(m_v);
        end
      end
      if (!nce && we) begin
        case (addr[3:2])
          2'd0: if (m_fifo.size() < DEPTH) m_fifo.push_back(wdata[7:0]); else m_ovf = 1'b1;
          2'd1: if (wdata[3]) m_ovf = 1'b0;
          2'd2: begin m_tx_en = wdata[0]; m_irq_en = wdata[1]; end
          default: m_div = wdata[15:0];
        endcase
      end
    end
  end

  function automatic logic [31:0] m_rdata(input logic [3:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a[3:2])
      2'd1: begin
        r[0]   = (m_line.size() != 0);
        r[1]   = (m_fifo.size() == DEPTH);
        r[2]   = (m_fifo.size() == 0);
        r[3]   = m_ovf;
        r[8:4] = 5'(m_fifo.size());
      end
      2'd2: r[1:0] = {m_irq_en, m_tx_en};
      2'd3: r[15:0] = m_div;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check_eq("txd", txd, (m_line.size() != 0) ? m_line[0] : 1'b1);
    check_eq("irq", irq, m_irq_en && m_fifo.size() == 0 && m_line.size() == 0);
    if (!nce && re) check_eq("rdata", rdata, m_rdata(addr));
    else            check_eq("rdata_idle", rdata, 32'h0);
  end

  // Lengths of low runs on txd (start bits when the payload is 0xFF).
  int run_len = 0;
  int runs[$];
  always @(negedge clk) begin
    if (txd == 1'b0) run_len++;
    else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    nce = 1'b0; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    nce = 1'b1; we = 1'b0; wdata = $urandom;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    nce = 1'b0; re = 1'b1; addr = a;
    @(negedge clk);
    d = rdata;
    @(posedge clk); #1;
    nce = 1'b1; re = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((m_line.size() != 0 || m_fifo.size() != 0) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_in_time", n < max_cyc, 1'b1);
  endtask

  // Waits (bounded) for a start bit, then records n txd samples and busy clocks.
  task automatic capture(input int n, output logic [79:0] v, output int busy_n);
    bit found;
    found  = 1'b0;
    v      = '0;
    busy_n = 0;
    nce = 1'b0; re = 1'b1; addr = 4'h4;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (txd == 1'b0) found = 1'b1;
    end
    check_eq("frame_start_seen", found, 1'b1);
    v[0]   = txd;
    busy_n = int'(rdata[0]);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      v[i]   = txd;
      busy_n = busy_n + int'(rdata[0]);
    end
  endtask

  logic [31:0] rd;
  logic [79:0] vec;
  int          busy_n;
  int          lows;

  initial begin
    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_txd", txd, 1'b1);
    check_eq("rst_irq", irq, 1'b0);
    bus_read(4'h4, rd); check_eq("rst_status", rd, 32'h4);
    bus_read(4'h8, rd); check_eq("rst_ctrl", rd, 32'h0);
    bus_read(4'hC, rd); check_eq("rst_divisor", rd, 32'd16);
    bus_read(4'h0, rd); check_eq("txdata_reads_0", rd, 32'h0);

    // 0xA5 at divisor 4: 40-clock frame, LSB first
    bus_write(4'hC, 32'd4);
    bus_write(4'h0, 32'hFFFF_FFA5);
    bus_write(4'h8, 32'h1);
    capture(40, vec, busy_n);
    check_eq("a5_frame", vec[39:0], 40'hFF0F00F0F0);
    check_eq("a5_busy_clks", busy_n, 40);
    @(negedge clk);
    check_eq("a5_busy_after", rdata[0], 1'b0);
    @(posedge clk); #1;
    nce = 1'b1; re = 1'b0;

    // Overflow with transmitter disabled
    bus_write(4'h8, 32'h0);
    for (int i = 0; i < 9; i++) bus_write(4'h0, $urandom);
    bus_read(4'h4, rd); check_eq("ovf_status", rd, 32'h8A);
    bus_write(4'h4, 32'hFFFF_FFF7);
    bus_read(4'h4, rd); check_eq("status_ro_bits", rd, 32'h8A);
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, rd); check_eq("ovf_cleared", rd, 32'h82);
    bus_write(4'hC, 32'd1);
    bus_write(4'h8, 32'h1);
    wait_idle(500);
    bus_write(4'h8, 32'h0);
    bus_read(4'h4, rd); check_eq("drained_status", rd, 32'h4);

    // Back-to-back frames
    bus_write(4'hC, 32'd4);
    bus_write(4'h0, 32'h01);
    bus_write(4'h0, 32'h02);
    bus_write(4'h8, 32'h1);
    capture(80, vec, busy_n);
    check_eq("b2b_frame1", vec[39:0], 40'hF0000000F0);
    check_eq("b2b_frame2", vec[79:40], 40'hF000000F00);
    check_eq("b2b_busy_clks", busy_n, 80);
    @(posedge clk); #1;
    nce = 1'b1; re = 1'b0;
    wait_idle(200);

    // Divisor change mid-frame, then divisor 0
    bus_write(4'h8, 32'h0);
    bus_write(4'h0, 32'hFF);
    bus_write(4'h0, 32'hFF);
    runs.delete();
    bus_write(4'h8, 32'h1);
    bus_write(4'hC, 32'd2);
    wait_idle(500);
    check_eq("div_runs", runs.size(), 2);
    check_eq("div_old_bits", (runs.size() > 0) ? runs[0] : 0, 4);
    check_eq("div_new_bits", (runs.size() > 1) ? runs[1] : 0, 2);
    bus_write(4'hC, 32'd0);
    runs.delete();
    bus_write(4'h0, 32'hFF);
    wait_idle(200);
    @(negedge clk);
    check_eq("div0_bits", (runs.size() > 0) ? runs[0] : 0, 1);

    // irq behaviour around a single frame
    bus_write(4'hC, 32'd2);
    bus_write(4'h8, 32'h3);
    check_eq("irq_idle_empty", irq, 1'b1);
    bus_write(4'h0, 32'h5A);
    lows = 0;
    for (int i = 0; i < 100 && irq == 1'b0; i++) begin
      @(negedge clk);
      if (irq == 1'b0) lows++;
    end
    check_eq("irq_low_clks", lows, 21);
    wait_idle(200);

    // Asynchronous reset in the middle of a DATA bit
    bus_write(4'h8, 32'h0);
    bus_write(4'hC, 32'd4);
    bus_write(4'h0, 32'h3C);
    bus_write(4'h8, 32'h1);
    repeat (10) @(posedge clk);
    #1 check_eq("pre_rst_txd", txd, 1'b0);
    #1 rst = 1'b1;
    #1 check_eq("rst_async_txd", txd, 1'b1);
    nce = 1'b0; re = 1'b1; addr = 4'h4;
    #1 check_eq("rst_mid_status", rdata, 32'h4);
    addr = 4'hC;
    #1 check_eq("rst_mid_divisor", rdata, 32'd16);
    addr = 4'h8;
    #1 check_eq("rst_mid_ctrl", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; nce = 1'b1; re = 1'b0;

    // Randomised traffic against the model
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: bus_write({2'b00, 2'($urandom)}, $urandom);
        4: bus_write({2'b10, 2'($urandom)}, {$urandom, 1'b1} >> ($urandom_range(0, 3) == 0 ? 1 : 0));
        5: bus_write({2'b11, 2'($urandom)}, {$urandom_range(0, 65535) << 16 | $urandom_range(0, 3)});
        6: bus_write({2'b01, 2'($urandom)}, $urandom);
        7: bus_read(4'($urandom), rd);
        8: repeat ($urandom_range(0, 30)) @(posedge clk);
        default: begin
          @(posedge clk); #1;
          nce = 1'b1; we = 1'b1; addr = 4'($urandom); wdata = $urandom;
          @(posedge clk); #1;
          we = 1'b0;
        end
      endcase
      #1;
    end
    bus_write(4'h8, 32'h1);
    wait_idle(3000);
    bus_read(4'h4, rd);
    check_eq("final_empty", rd[2], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-high.
REQ-002 Parameter CLK_DIV, default 16, SHALL set the reset value of the bit-period divisor in clocks.
REQ-003 Parameter FIFO_DEPTH, default 8 (power of two, 2..16), SHALL set the transmit FIFO entries.
REQ-004 Port clk, input, 1, SHALL be the CPU clock.
REQ-005 Port rst, input, 1, SHALL be the asynchronous active-high reset.
REQ-006 Port nce, input, 1, SHALL be the active-low chip enable from the I/O address decode.
REQ-007 Port we, input, 1, SHALL be the register write strobe, qualified by nce low.
REQ-008 Port re, input, 1, SHALL be the register read strobe, qualified by nce low.
REQ-009 Port addr, input, 4, SHALL select a register by byte address; bits [3:2] decode, bits [1:0] ignored.
REQ-010 Port wdata, input, 32, SHALL carry store data from the CPU B register.
REQ-011 Port rdata, output, 32, SHALL carry register read data.
REQ-012 Port txd, output, 1, SHALL be the serial line, idle high.
REQ-013 Port irq, output, 1, SHALL be the level interrupt request.

Function
REQ-014 Register map SHALL be: 0x0 TXDATA (W), 0x4 STATUS (R/W1C), 0x8 CTRL (R/W), 0xC DIVISOR (R/W).
REQ-015 Writing TXDATA SHALL enqueue wdata[7:0]; all other wdata bits SHALL be ignored.
REQ-016 STATUS SHALL read as: bit0 busy, bit1 full, bit2 empty, bit3 overflow, bits[8:4] count (0..FIFO_DEPTH), all others 0.
REQ-017 Writing STATUS with bit3=1 SHALL clear overflow; other STATUS bits SHALL be read-only.
REQ-018 CTRL SHALL be: bit0 tx_en, bit1 irq_en, all others reading 0.
REQ-019 DIVISOR SHALL be 16 bits in [15:0]; a value of 0 SHALL behave as 1.
REQ-020 rdata SHALL be combinational, the selected register when nce=0 and re=1, else 32'h0; TXDATA SHALL read 0.
REQ-021 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-022 IDLE->START SHALL occur when tx_en=1 and the FIFO is not empty; on this transition the head byte is popped and the divisor is latched.
REQ-023 Each of START (txd=0), the 8 DATA bits (LSB first), and STOP (txd=1) SHALL last exactly the latched divisor clocks.
REQ-024 STOP SHALL go to START directly, with no idle clock, if tx_en=1 and the FIFO is not empty, else to IDLE.
REQ-025 busy SHALL be 1 in any state other than IDLE.
REQ-026 A TXDATA write when full SHALL be dropped and SHALL set overflow; a write in the same clock as a pop SHALL be accepted.
REQ-027 Clearing tx_en mid-frame SHALL let the current frame finish; no further pop SHALL occur.
REQ-028 A DIVISOR write mid-frame SHALL take effect only from the next START.
REQ-029 irq SHALL equal irq_en AND empty AND NOT busy.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 Reset SHALL set: FSM IDLE, txd=1, FIFO empty (count 0), overflow=0, CTRL=0, DIVISOR=CLK_DIV, irq=0, rdata driven by REQ-020.
REQ-032 Reset asserted mid-frame SHALL immediately drive txd high and discard the frame and FIFO contents.

Structure
REQ-033 A shared package SHALL hold the register offsets, the STATUS and CTRL bit indices, and the FSM state enum.
REQ-034 The FIFO SHALL be a sub-module named sync_fifo_8b, with push, pop, full, empty and count.

Verification
REQ-035 Bench: DIVISOR=4, tx_en=1, write 0xA5 -> txd start bit low for 4 clk, then bits 1,0,1,0,0,1,0,1, then stop high; busy high for 40 clk.
REQ-036 Bench: with tx_en=0, write 9 bytes (depth 8) -> count=8, full=1, overflow=1; write STATUS 0x8 -> overflow=0.
REQ-037 Bench: queue 0x01 and 0x02, enable -> two frames back to back with no idle clock between the stop and start bits.
REQ-038 Bench: change DIVISOR from 4 to 2 mid-frame -> current frame keeps 4-clk bits, next frame uses 2-clk bits; DIVISOR=0 -> 1-clk bits.
REQ-039 Bench: irq_en=1, send one byte -> irq=0 while busy, rises the clock after returning to IDLE with FIFO empty.
REQ-040 Bench: assert rst during a DATA bit -> txd=1 asynchronously, STATUS reads 0x4 (empty, count 0), DIVISOR reads CLK_DIV.
